// File: rtl/dff_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dff_ctrl_pkg
//  Purpose  : Shared opcodes and FSM state encoding for dff_bank_controller
//  Revision : 1.0  initial release
// ============================================================================
package dff_ctrl_pkg;

    // Command opcodes (3'b110 / 3'b111 decode as NOP)
    localparam logic [2:0] CMD_NOP    = 3'b000;
    localparam logic [2:0] CMD_LOAD   = 3'b001;
    localparam logic [2:0] CMD_PRESET = 3'b010;
    localparam logic [2:0] CMD_CLEAR  = 3'b011;
    localparam logic [2:0] CMD_SHIFT  = 3'b100;
    localparam logic [2:0] CMD_INVERT = 3'b101;

    // Controller state encoding
    localparam int         ST_W     = 2;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_EXEC  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

endpackage : dff_ctrl_pkg
`default_nettype wire

// File: rtl/dff_cell.sv
`default_nettype none
// ============================================================================
//  Module   : dff_cell
//  Purpose  : Single D flip-flop with asynchronous active-high clear and
//             complementary outputs. Qbar is derived combinationally so it
//             reads all-ones while clear is held.
//  Revision : 1.0  initial release
// ============================================================================
module dff_cell (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q,
    output logic o_qbar
);

    logic r_q;

    // Storage element: clears asynchronously, captures D on every rising edge
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_q <= 1'b0;
        end else begin
            r_q <= i_d;
        end
    end

    assign o_q    = r_q;
    assign o_qbar = ~r_q;

endmodule : dff_cell
`default_nettype wire

// File: rtl/dff_bank_controller.sv
`default_nettype none
// ============================================================================
//  Module   : dff_bank_controller
//  Purpose  : Command-driven sequencer for a WIDTH-bit bank of dff_cell
//             instances. Accepts LOAD / PRESET / CLEAR / SHIFT / INVERT / NOP
//             over a valid/ready handshake and pulses DONE on completion.
//  Config   : define DFF_PARITY_EN to add a registered PARITY output
//             (XOR of all Q bits, updated on the same edge as Q).
//  Revision : 1.0  initial release
// ============================================================================
module dff_bank_controller
    import dff_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             CMD_VALID,
    output logic             CMD_READY,
    input  logic [2:0]       CMD,
    input  logic [WIDTH-1:0] DATA_IN,
    input  logic             SER_IN,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] QBAR,
    output logic             BUSY,
`ifdef DFF_PARITY_EN
    output logic             PARITY,
`endif
    output logic             DONE
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(WIDTH - 1);

    logic [ST_W-1:0]  r_state;
    logic [ST_W-1:0]  w_state_nxt;
    logic [2:0]       r_cmd;
    logic [WIDTH-1:0] r_data;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_qbar;
    logic [WIDTH-1:0] w_d;
    logic             w_accept;
    logic             w_shift_last;

    assign w_accept     = CMD_VALID && CMD_READY;
    assign w_shift_last = (r_cnt == C_CNT_LAST);

    // State register; reset drops any in-flight command back to IDLE
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode: SHIFT gets its own multi-edge state, all else one EXEC edge
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (CMD_VALID) begin
                    w_state_nxt = (CMD == CMD_SHIFT) ? ST_SHIFT : ST_EXEC;
                end
            end
            ST_EXEC:  w_state_nxt = ST_DONE;
            ST_SHIFT: begin
                if (w_shift_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Output decode: handshake/status flags and the D input for every cell
    always_comb begin
        CMD_READY = (r_state == ST_IDLE);
        BUSY      = (r_state != ST_IDLE);
        DONE      = (r_state == ST_DONE);
        w_d       = w_q;
        case (r_state)
            ST_EXEC: begin
                case (r_cmd)
                    CMD_LOAD:   w_d = r_data;
                    CMD_PRESET: w_d = '1;
                    CMD_CLEAR:  w_d = '0;
                    CMD_INVERT: w_d = ~w_q;
                    default:    w_d = w_q;
                endcase
            end
            ST_SHIFT: w_d = {w_q[WIDTH-2:0], SER_IN};
            default:  w_d = w_q;
        endcase
    end

    // Command capture: opcode and load data are frozen at acceptance
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            r_cmd  <= CMD_NOP;
            r_data <= '0;
        end else if (w_accept) begin
            r_cmd  <= CMD;
            r_data <= DATA_IN;
        end
    end

    // Shift counter: held at zero outside SHIFT, saturates at WIDTH-1
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            r_cnt <= '0;
        end else if (r_state != ST_SHIFT) begin
            r_cnt <= '0;
        end else if (!w_shift_last) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // The bank itself: one flip-flop cell per bit
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
            dff_cell u_cell (
                .i_clk  (CLK),
                .i_rst  (CLR),
                .i_d    (w_d[gi]),
                .o_q    (w_q[gi]),
                .o_qbar (w_qbar[gi])
            );
        end
    endgenerate

    assign Q    = w_q;
    assign QBAR = w_qbar;

`ifdef DFF_PARITY_EN
    logic r_parity;

    // Parity tracks the value the bank captures on the same edge
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            r_parity <= 1'b0;
        end else begin
            r_parity <= ^w_d;
        end
    end

    assign PARITY = r_parity;
`endif

endmodule : dff_bank_controller
`default_nettype wire

// File: tb/tb_dff_bank_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dff_bank_controller
//  Purpose  : Self-checking bench for dff_bank_controller (WIDTH=8) using a
//             behavioural model of the bank value and handshake timing.
//  Config   : define DFF_PARITY_EN to also check PARITY.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dff_bank_controller;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         clr;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [2:0]   cmd;
    logic [W-1:0] data_in;
    logic         ser_in;
    logic [W-1:0] q;
    logic [W-1:0] qbar;
    logic         busy;
    logic         done;
`ifdef DFF_PARITY_EN
    logic         parity;
`endif

    int           n_tests = 0;
    int           n_fail  = 0;
    logic [W-1:0] exp_q;

    always #5 clk = ~clk;

    dff_bank_controller #(.WIDTH(W)) u_dut (
        .CLK       (clk),
        .CLR       (clr),
        .CMD_VALID (cmd_valid),
        .CMD_READY (cmd_ready),
        .CMD       (cmd),
        .DATA_IN   (data_in),
        .SER_IN    (ser_in),
        .Q         (q),
        .QBAR      (qbar),
        .BUSY      (busy),
`ifdef DFF_PARITY_EN
        .PARITY    (parity),
`endif
        .DONE      (done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Bank value, its complement and (optionally) parity against the model
    task automatic chk_bank(input string tag);
        logic [W-1:0] inv;
        inv = ~exp_q;
        chk({tag, "_q"}, 32'(q), 32'(exp_q));
        chk({tag, "_qbar"}, 32'(qbar), 32'(inv));
`ifdef DFF_PARITY_EN
        chk({tag, "_parity"}, 32'(parity), 32'(^exp_q));
`endif
    endtask

    // Model rule for single-step opcodes
    function automatic logic [W-1:0] model_op(input logic [2:0] op, input logic [W-1:0] cur,
                                              input logic [W-1:0] d);
        case (op)
            3'd1:    return d;
            3'd2:    return {W{1'b1}};
            3'd3:    return '0;
            3'd5:    return ~cur;
            default: return cur;
        endcase
    endfunction

    // Full transaction from IDLE; entered and left on a falling edge.
    // ser holds the serial sequence, first bit in the MSB.
    task automatic do_cmd(input logic [2:0] op, input logic [W-1:0] data, input logic [W-1:0] ser);
        logic b;
        chk("ready_idle", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd       = op;
        data_in   = data;
        @(posedge clk); @(negedge clk);
        cmd_valid = 1'b0;
        cmd       = 3'($urandom);
        data_in   = W'($urandom);
        chk("busy_acc", 32'(busy), 32'd1);
        chk("ready_acc", 32'(cmd_ready), 32'd0);
        if (op == 3'd4) begin
            for (int i = 0; i < W; i++) begin
                b      = ser[W-1-i];
                ser_in = b;
                @(posedge clk); @(negedge clk);
                ser_in = 1'($urandom);
                exp_q  = W'((int'(exp_q) * 2 + int'(b)) % (1 << W));
                chk("shift_done", 32'(done), (i == W-1) ? 32'd1 : 32'd0);
                chk_bank("shift");
            end
        end else begin
            chk("done_early", 32'(done), 32'd0);
            chk_bank("hold");
            @(posedge clk); @(negedge clk);
            exp_q = model_op(op, exp_q, data);
            chk("done_pulse", 32'(done), 32'd1);
            chk("ready_done", 32'(cmd_ready), 32'd0);
            chk_bank("exec");
        end
        @(posedge clk); @(negedge clk);
        chk("done_end", 32'(done), 32'd0);
        chk("busy_end", 32'(busy), 32'd0);
        chk("ready_end", 32'(cmd_ready), 32'd1);
        chk_bank("idle");
    endtask

    initial begin
        logic         saw_done;
        logic [W-1:0] lat;

        clr       = 1'b1;
        cmd_valid = 1'b0;
        cmd       = 3'd0;
        data_in   = '0;
        ser_in    = 1'b0;
        exp_q     = '0;

        // Reset state
        #12;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk_bank("rst");
        @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
        chk("rst_ready", 32'(cmd_ready), 32'd1);

        // LOAD A5, PRESET, INVERT, LOAD 3C, CLEAR
        do_cmd(3'd1, 8'hA5, '0);
        do_cmd(3'd2, 8'h00, '0);
        do_cmd(3'd5, 8'h00, '0);
        do_cmd(3'd1, 8'h3C, '0);
        do_cmd(3'd3, 8'h00, '0);

        // SHIFT 1,0,1,1,0,0,1,0 -> B2
        do_cmd(3'd4, '0, 8'b1011_0010);
        chk("shift_b2", 32'(q), 32'hB2);

        // Opcode 111 leaves Q unchanged but still completes
        do_cmd(3'd7, 8'h55, '0);
`ifdef DFF_PARITY_EN
        do_cmd(3'd1, 8'h07, '0);
        chk("par_07", 32'(parity), 32'd1);
        do_cmd(3'd1, 8'h03, '0);
        chk("par_03", 32'(parity), 32'd0);
`endif

        // Reset in the middle of a SHIFT after three shift edges
        do_cmd(3'd1, 8'h5A, '0);
        cmd_valid = 1'b1;
        cmd       = 3'd4;
        @(posedge clk); @(negedge clk);
        cmd_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ser_in = 1'b1;
            @(posedge clk); @(negedge clk);
        end
        #2 clr = 1'b1;
        #1;
        exp_q = '0;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk_bank("midrst");
        @(negedge clk);
        clr = 1'b0;
        #1;
        chk("midrst_ready", 32'(cmd_ready), 32'd1);
        saw_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        chk("midrst_no_done", 32'(saw_done), 32'd0);
        chk_bank("midrst_hold");

        // CMD_VALID held with LOAD and changing data: accept every third cycle
        cmd_valid = 1'b1;
        cmd       = 3'd1;
        lat       = '0;
        for (int c = 0; c < 9; c++) begin
            data_in = W'($urandom);
            if (c % 3 == 0) lat = data_in;
            chk("b2b_ready", 32'(cmd_ready), (c % 3 == 0) ? 32'd1 : 32'd0);
            chk("b2b_done", 32'(done), (c % 3 == 2) ? 32'd1 : 32'd0);
            @(posedge clk);
            if (c % 3 == 1) exp_q = lat;
            @(negedge clk);
            chk_bank("b2b");
        end
        cmd_valid = 1'b0;

        // Randomized commands against the model
        for (int n = 0; n < 40; n++) begin
            do_cmd(3'($urandom_range(0, 7)), W'($urandom), W'($urandom));
        end

        // Reset from a non-zero value
        do_cmd(3'd2, '0, '0);
        #1 clr = 1'b1;
        #1;
        exp_q = '0;
        chk_bank("final_rst");
        @(negedge clk);
        clr = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Absolute time guard so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, tests %0d", n_tests);
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_dff_bank_controller
`default_nettype wire
